bf16_fx_normalizer: RTL

- Converts one signed fixed-point partial-sum plus a block exponent back into a single BF16 word.
- Sits on the output side of the CIM floating-point MAC datapath. It takes the two's-complement aligned sum the array produces and returns a normalized, rounded BF16 result.
- Uses a valid/ready handshake on both sides.
- Normalization is iterative: one bit per cycle.

---
 rtl/bf16_fx_normalizer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bf16_fx_normalizer.sv
// rtl/bf16_fx_normalizer.sv - signed fixed-point sum plus block exponent to BF16, one normalize bit per cycle
module bf16_fx_normalizer #(
  parameter int SUM_W     = 17,
  parameter int FRAC_BITS = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [7:0]       in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_bf16
);

  // Shift count never exceeds SUM_W-1, so clog2(SUM_W) bits always suffice.
  localparam int CNT_W = $clog2(SUM_W);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SUM_W-1:0] SUM_ONE = {{(SUM_W-1){1'b0}}, 1'b1};
  // Exponent offset of the MSB position relative to the fixed-point scale.
  localparam logic [9:0] E_OFS = 10'(SUM_W - 1 - FRAC_BITS);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [SUM_W-1:0] mag_q, mag_d;
  logic [7:0]       exp_q, exp_d;
  logic [CNT_W-1:0] shift_q, shift_d;
  logic [15:0]      bf16_q, bf16_d;
  logic             in_ready_q, out_valid_q;

  logic [SUM_W-1:0] abs_sum;
  logic [6:0]       m_raw, m_rnd;
  logic             g_bit, s_bit, rnd_inc;
  logic [9:0]       e_raw, e_rnd;
  logic [15:0]      round_word;

  // Magnitude of the incoming sum; the most negative value maps to 2^(SUM_W-1) exactly.
  always_comb begin
    abs_sum = in_sum;
    if (in_sum[SUM_W-1]) begin
      abs_sum = (~in_sum) + SUM_ONE;
    end
  end

  // Round-to-nearest-even on the normalized magnitude, then exponent saturation.
  always_comb begin
    m_raw   = mag_q[SUM_W-2 -: 7];
    g_bit   = mag_q[SUM_W-9];
    s_bit   = |mag_q[SUM_W-10:0];
    rnd_inc = g_bit & (s_bit | m_raw[0]);
    e_raw   = {2'b00, exp_q} + E_OFS - 10'(shift_q);
    m_rnd   = m_raw;
    e_rnd   = e_raw;
    if (rnd_inc) begin
      if (m_raw == 7'h7F) begin
        m_rnd = 7'h00;
        e_rnd = e_raw + 10'd1;
      end else begin
        m_rnd = m_raw + 7'd1;
      end
    end
    if ($signed(e_rnd) >= $signed(10'sd255)) begin
      round_word = {sign_q, 8'hFF, 7'h00};
    end else if ($signed(e_rnd) <= $signed(10'sd0)) begin
      round_word = {sign_q, 8'h00, 7'h00};
    end else begin
      round_word = {sign_q, e_rnd[7:0], m_rnd};
    end
  end

  // Next-state and datapath updates for the accept / normalize / round / output sequence.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    shift_d = shift_q;
    bf16_d  = bf16_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sum[SUM_W-1];
          mag_d   = abs_sum;
          exp_d   = in_exp;
          shift_d = '0;
          if (in_sum == '0) begin
            bf16_d  = 16'h0000;
            state_d = OUT;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[SUM_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d   = mag_q << 1;
          shift_d = shift_q + CNT_ONE;
        end
      end
      ROUND: begin
        bf16_d  = round_word;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= 8'h00;
      shift_q     <= '0;
      bf16_q      <= 16'h0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      shift_q     <= shift_d;
      bf16_q      <= bf16_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == OUT);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bf16  = bf16_q;

endmodule
